// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and helpers for the GPR write scoreboard.
// Register indices, the r0 sentinel and the debug total width live here.
package reg_scoreboard_pkg;

    localparam int REG_W  = 5;
    localparam int NREG   = 32;
    localparam int INFL_W = 6;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    // r0 is hardwired to zero, so nothing that names it is ever tracked.
    function automatic logic is_tracked(input logic [REG_W-1:0] addr);
        return addr != ZERO_REG;
    endfunction

endpackage

// File: rtl/reg_scoreboard_cell.sv
// One GPR's scoreboard entry: outstanding-writer count and, of those,
// the count whose result is not yet forwardable.
module reg_sb_cell #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic inc,
    input  logic inc_long,
    input  logic dec_pend,
    input  logic dec_long,
    output logic long_busy,
    output logic pend_full,
    output logic pend_nz
);

    logic [CNT_W-1:0] pend_cnt;
    logic [CNT_W-1:0] long_cnt;
    logic             pend_dn;
    logic             long_up;
    logic             long_dn;

    // Decrements on an empty counter are dropped so stray events cannot underflow.
    assign pend_dn = dec_pend && (pend_cnt != '0);
    assign long_up = inc && inc_long;
    assign long_dn = dec_long && (long_cnt != '0);

    // NOTE: counters are state, so they take non-blocking assignments and are cleared by reset;
    // an unreset counter would report phantom busy registers after power-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt <= '0;
            long_cnt <= '0;
        end else if (flush) begin
            pend_cnt <= '0;
            long_cnt <= '0;
        end else begin
            if (inc && !pend_dn)
                pend_cnt <= pend_cnt + CNT_W'(1);
            else if (!inc && pend_dn)
                pend_cnt <= pend_cnt - CNT_W'(1);

            if (long_up && !long_dn)
                long_cnt <= long_cnt + CNT_W'(1);
            else if (!long_up && long_dn)
                long_cnt <= long_cnt - CNT_W'(1);
        end
    end

    assign long_busy = (long_cnt != '0);
    assign pend_full = (pend_cnt == {CNT_W{1'b1}});
    assign pend_nz   = (pend_cnt != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side GPR scoreboard: stalls decode while a source awaits a load or
// mul/div result that the EX bypass cannot yet supply, or a writer count is full.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              iss_valid,
    input  logic              iss_dst_en,
    input  logic [REG_W-1:0]  iss_dst,
    input  logic              iss_long,
    input  logic [REG_W-1:0]  rs_addr,
    input  logic [REG_W-1:0]  rt_addr,
    input  logic              rdy_en,
    input  logic [REG_W-1:0]  rdy_addr,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              stall,
    output logic [INFL_W-1:0] inflight
);

    logic [NREG-1:0] long_busy;
    logic [NREG-1:0] pend_full;
    logic [NREG-1:0] pend_nz;
    logic            sat_hit;
    logic            accept;
    logic            issue_write;
    logic            wb_dec;

    // Slot 0 stands in for r0: permanently idle, so the read muxes need no special case.
    assign long_busy[0] = 1'b0;
    assign pend_full[0] = 1'b0;
    assign pend_nz[0]   = 1'b0;

    assign rs_busy = is_tracked(rs_addr) && long_busy[rs_addr];
    assign rt_busy = is_tracked(rt_addr) && long_busy[rt_addr];
    assign sat_hit = iss_dst_en && is_tracked(iss_dst) && pend_full[iss_dst];
    assign stall   = rs_busy || rt_busy || sat_hit;

    assign accept      = iss_valid && !stall;
    assign issue_write = accept && iss_dst_en && is_tracked(iss_dst);
    assign wb_dec      = wb_en && is_tracked(wb_addr) && pend_nz[wb_addr];

    for (genvar r = 1; r < NREG; r++) begin : g_cell
        reg_sb_cell #(.CNT_W(CNT_W)) u_cell (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .inc       (issue_write && (iss_dst == REG_W'(r))),
            .inc_long  (iss_long),
            .dec_pend  (wb_en && (wb_addr == REG_W'(r))),
            .dec_long  (rdy_en && (rdy_addr == REG_W'(r))),
            .long_busy (long_busy[r]),
            .pend_full (pend_full[r]),
            .pend_nz   (pend_nz[r])
        );
    end

    // Running total moves in step with the per-register pending counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            inflight <= '0;
        else if (flush)
            inflight <= '0;
        else if (issue_write && !wb_dec)
            inflight <= inflight + INFL_W'(1);
        else if (!issue_write && wb_dec)
            inflight <= inflight - INFL_W'(1);
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios with literal
// expectations plus randomized traffic compared against a per-register count model.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       iss_valid;
    logic       iss_dst_en;
    logic [4:0] iss_dst;
    logic       iss_long;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic       rdy_en;
    logic [4:0] rdy_addr;
    logic       wb_en;
    logic [4:0] wb_addr;
    logic       rs_busy;
    logic       rt_busy;
    logic       stall;
    logic [5:0] inflight;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Model: how many writers each register has outstanding, and how many are long.
    int m_pend [32];
    int m_long [32];

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .iss_valid  (iss_valid),
        .iss_dst_en (iss_dst_en),
        .iss_dst    (iss_dst),
        .iss_long   (iss_long),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rdy_en     (rdy_en),
        .rdy_addr   (rdy_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy),
        .stall      (stall),
        .inflight   (inflight)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] a);
        return (a != 5'd0) && (m_long[a] > 0);
    endfunction

    function automatic bit m_stall();
        bit sat;
        sat = iss_dst_en && (iss_dst != 5'd0) && (m_pend[iss_dst] == 3);
        return m_busy(rs_addr) || m_busy(rt_addr) || sat;
    endfunction

    function automatic int m_total();
        int s = 0;
        for (int i = 1; i < 32; i++) s += m_pend[i];
        return s % 64;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || (!rst && flush)) begin
            for (int i = 0; i < 32; i++) begin
                m_pend[i] = 0;
                m_long[i] = 0;
            end
        end else begin
            bit acc, wb_ok, rdy_ok;
            acc    = iss_valid && !m_stall() && iss_dst_en && (iss_dst != 5'd0);
            wb_ok  = wb_en && (wb_addr != 5'd0) && (m_pend[wb_addr] > 0);
            rdy_ok = rdy_en && (rdy_addr != 5'd0) && (m_long[rdy_addr] > 0);
            if (acc) begin
                m_pend[iss_dst]++;
                if (iss_long) m_long[iss_dst]++;
            end
            if (wb_ok)  m_pend[wb_addr]--;
            if (rdy_ok) m_long[rdy_addr]--;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("model_rs_busy", rs_busy, m_busy(rs_addr));
            check("model_rt_busy", rt_busy, m_busy(rt_addr));
            check("model_stall", stall, m_stall());
            check("model_inflight", inflight, m_total());
        end
    end

    task automatic idle();
        flush = 0; iss_valid = 0; iss_dst_en = 0; iss_dst = 0; iss_long = 0;
        rs_addr = 0; rt_addr = 0; rdy_en = 0; rdy_addr = 0; wb_en = 0; wb_addr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] dst, input logic lng);
        iss_valid = 1; iss_dst_en = 1; iss_dst = dst; iss_long = lng;
    endtask

    task automatic no_issue();
        iss_valid = 0; iss_dst_en = 0; iss_dst = 0; iss_long = 0;
    endtask

    task automatic randomize_inputs();
        logic [4:0] a;
        iss_valid  = ($urandom_range(0, 99) < 60);
        iss_dst_en = ($urandom_range(0, 99) < 80);
        iss_dst    = 5'($urandom_range(0, 15));
        iss_long   = ($urandom_range(0, 99) < 40);
        rs_addr    = 5'($urandom_range(0, 15));
        rt_addr    = 5'($urandom_range(0, 15));
        rdy_en     = ($urandom_range(0, 99) < 55);
        rdy_addr   = 5'($urandom_range(0, 15));
        // Writebacks only retire a short writer (or hit an idle register), matching
        // in-order completion where a long result becomes ready before it commits.
        a = 5'($urandom_range(0, 15));
        wb_addr = a;
        wb_en   = ($urandom_range(0, 99) < 50) && ((m_pend[a] > m_long[a]) || (m_pend[a] == 0));
        flush   = ($urandom_range(0, 99) < 2);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_rs_busy", rs_busy, 0);
        check("rst_rt_busy", rt_busy, 0);
        check("rst_inflight", inflight, 0);
        step();

        // Long producer blocks its consumer until ready
        issue(5, 1);
        @(negedge clk); check("lw_issue_stall", stall, 0);
        step(); no_issue(); rs_addr = 5;
        @(negedge clk);
        check("lw_rs_busy", rs_busy, 1);
        check("lw_stall", stall, 1);
        check("lw_inflight", inflight, 1);
        step(); rdy_en = 1; rdy_addr = 5;
        step(); rdy_en = 0;
        @(negedge clk);
        check("lw_rdy_stall", stall, 0);
        check("lw_rdy_rs_busy", rs_busy, 0);
        step(); wb_en = 1; wb_addr = 5;
        step(); wb_en = 0; rs_addr = 0;
        @(negedge clk); check("lw_wb_inflight", inflight, 0);
        step();

        // Short producer never stalls
        issue(7, 0);
        step(); no_issue(); rt_addr = 7;
        @(negedge clk);
        check("add_stall", stall, 0);
        check("add_rt_busy", rt_busy, 0);
        check("add_inflight", inflight, 1);
        step(); wb_en = 1; wb_addr = 7;
        step(); wb_en = 0; rt_addr = 0;
        @(negedge clk); check("add_wb_inflight", inflight, 0);
        step();

        // Writer counter saturation on r3
        issue(3, 0);
        repeat (3) step();
        @(negedge clk);
        check("sat_stall", stall, 1);
        check("sat_inflight", inflight, 3);
        step(); wb_en = 1; wb_addr = 3;
        @(negedge clk); check("sat_wb_same_cycle_stall", stall, 1);
        step(); wb_en = 0;
        @(negedge clk);
        check("sat_after_wb_stall", stall, 0);
        check("sat_after_wb_inflight", inflight, 2);
        step(); no_issue();
        @(negedge clk);
        check("sat_refill_inflight", inflight, 3);
        step(); wb_en = 1; wb_addr = 3;
        repeat (3) step();
        wb_en = 0;
        @(negedge clk); check("sat_drain_inflight", inflight, 0);
        step();

        // Flush overrides a same-cycle issue; r0 never tracked
        issue(9, 1);
        step(); issue(0, 1);
        step(); no_issue(); rs_addr = 9;
        @(negedge clk);
        check("fl_rs_busy_before", rs_busy, 1);
        check("fl_inflight_before", inflight, 1);
        step(); rs_addr = 0; issue(9, 1); flush = 1;
        step(); flush = 0; no_issue(); rs_addr = 9;
        @(negedge clk);
        check("fl_rs_busy_after", rs_busy, 0);
        check("fl_inflight_after", inflight, 0);
        step(); rs_addr = 0; rt_addr = 0;
        @(negedge clk);
        check("r0_rs_busy", rs_busy, 0);
        check("r0_rt_busy", rt_busy, 0);
        step();

        // Asynchronous reset in mid-cycle while stalled
        issue(4, 1);
        step(); no_issue(); rs_addr = 4;
        @(negedge clk); check("arst_pre_stall", stall, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_stall", stall, 0);
        check("arst_rs_busy", rs_busy, 0);
        check("arst_inflight", inflight, 0);
        #1 rst = 1'b0;
        step(); rs_addr = 0; wb_en = 1; wb_addr = 11; rdy_en = 1; rdy_addr = 12;
        step(); step(); wb_en = 0; rdy_en = 0; rs_addr = 12;
        @(negedge clk);
        check("stray_rs_busy", rs_busy, 0);
        check("stray_inflight", inflight, 0);
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            randomize_inputs();
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
